// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: req/addr handshake with in-order rvalid/rdata responses.
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  // Fetch unit side
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  // Instruction memory side
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, imem request issue, prefetch FIFO
// feeding decode, and branch redirect with flushing of stale in-flight responses.
// Optional compile-time feature IFU_BYPASS_EN: a response arriving while the FIFO is
// empty is presented to decode in the same cycle instead of one cycle later.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_en,
  input  logic               i_branch_taken,
  input  logic [31:0]        i_branch_target,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        o_instr,
  output logic [31:0]        o_pc,
  output logic               o_instr_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               active_q;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0]   tag_rd_q, tag_rd_d;
  logic [31:0]        data_q [FIFO_DEPTH];
  logic [31:0]        data_d [FIFO_DEPTH];
  logic [31:0]        pcs_q  [FIFO_DEPTH];
  logic [31:0]        pcs_d  [FIFO_DEPTH];
  logic [31:0]        tag_q  [FIFO_DEPTH];
  logic [31:0]        tag_d  [FIFO_DEPTH];

  logic has_room;
  logic grant;
  logic resp;
  logic drop_resp;
  logic keep_resp;
  logic pop;
  logic fifo_pop;
  logic push;

  // Issue only while buffered plus in-flight words leave room; never on a redirect cycle.
  // active_q keeps req low during reset and the first cycle after release.
  assign has_room  = ({1'b0, count_q} + {1'b0, outstanding_q}) < SUM_W'(FIFO_DEPTH);
  assign imem.req  = active_q && has_room && !i_branch_taken;
  assign imem.addr = fetch_pc_q;

  assign grant     = imem.req && imem.gnt;
  assign resp      = imem.rvalid;
  assign drop_resp = resp && (state_q == ST_FLUSH);
  assign keep_resp = resp && (state_q == ST_RUN) && !i_branch_taken;
  assign pop       = i_clk_en && o_instr_ready && !i_branch_taken;

`ifdef IFU_BYPASS_EN
  logic bypass;

  // Empty FIFO: forward the live response straight to decode; store it only if not consumed.
  assign bypass        = keep_resp && (count_q == '0);
  assign fifo_pop      = pop && !bypass;
  assign push          = keep_resp && !(bypass && pop);
  assign o_instr_ready = (count_q != '0) || bypass;
  assign o_instr       = bypass ? imem.rdata : data_q[rd_ptr_q];
  assign o_pc          = bypass ? tag_q[tag_rd_q] : pcs_q[rd_ptr_q];
`else
  // Decode always sees the registered FIFO head.
  assign fifo_pop      = pop;
  assign push          = keep_resp;
  assign o_instr_ready = (count_q != '0);
  assign o_instr       = data_q[rd_ptr_q];
  assign o_pc          = pcs_q[rd_ptr_q];
`endif

  // Next-state: redirect overrides issue/push/pop; otherwise fetch, track tags, fill/drain FIFO.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    data_d        = data_q;
    pcs_d         = pcs_q;
    tag_d         = tag_q;

    if (i_branch_taken) begin
      // Every word still in flight belongs to the old path and must be discarded.
      fetch_pc_d    = i_branch_target & 32'hFFFF_FFFC;
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp);
      drop_cnt_d    = outstanding_d;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      tag_wr_d      = '0;
      tag_rd_d      = '0;
      state_d       = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp);

      if (grant) begin
        fetch_pc_d      = fetch_pc_q + 32'd4;
        tag_d[tag_wr_q] = fetch_pc_q;
        tag_wr_d        = tag_wr_q + PTR_W'(1);
      end

      if (drop_resp) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end

      if (keep_resp) begin
        tag_rd_d = tag_rd_q + PTR_W'(1);
      end

      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push) begin
        data_d[wr_ptr_q] = imem.rdata;
        pcs_d[wr_ptr_q]  = tag_q[tag_rd_q];
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);

      unique case (state_q)
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = (drop_cnt_d == '0) ? ST_RUN : ST_FLUSH;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // State register; reset discards all in-flight and buffered state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_RUN;
      active_q      <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      data_q        <= '{default: '0};
      pcs_q         <= '{default: '0};
      tag_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      data_q        <= data_d;
      pcs_q         <= pcs_d;
      tag_q         <= tag_d;
    end
  end

  // Occupancy bounds that the issue rule guarantees.
  a_fifo_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= CNT_W'(FIFO_DEPTH));
  a_outstanding_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    outstanding_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with variable latency,
// scoreboard of expected {pc, instr} pushed at grant and compared whenever decode sees a head.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  typedef struct {
    int unsigned lat;
    int unsigned pre;
    logic [31:0] t1;
    logic [31:0] target;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] pc0;
  } redir_vec_t;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        branch;
  logic [31:0] target;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;

  instr_fetch_unit_if imem_bus();

  instr_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_clk_en        (clk_en),
    .i_branch_taken  (branch),
    .i_branch_target (target),
    .imem            (imem_bus),
    .o_instr         (instr),
    .o_pc            (pc),
    .o_instr_ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_tot;
  int unsigned cyc;
  int unsigned n_pops;
  logic        en_v;
  logic        br_v;
  logic        gnt_v;
  logic [31:0] tgt_v;
  int unsigned lat_v;
  logic [31:0] exp_addr;
  logic        prev_br;
  logic        s_req;
  logic        s_grant;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  exp_t        exp_q[$];
  mreq_t       mq[$];
  redir_vec_t  vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F69;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_tot++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_bus.req), 32'd0);
    chk({tag, "_addr"},  imem_bus.addr, RESET_PC);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_pc"},    pc, 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
  endtask

  // One clock: drive at negedge, settle, check, update model; DUT acts on next posedge.
  task automatic do_cycle();
    @(negedge clk);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = mem_word(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = 32'hDEAD_BEEF;
    end
    clk_en       = en_v;
    branch       = br_v;
    target       = tgt_v;
    imem_bus.gnt = gnt_v;
    #1;
    s_req   = imem_bus.req;
    s_addr  = imem_bus.addr;
    s_ready = ready;
    s_pc    = pc;
    s_grant = s_req && gnt_v;
    if (br_v) chk("req_during_redirect", 32'(s_req), 32'd0);
    if (prev_br) chk("ready_after_redirect", 32'(s_ready), 32'd0);
    if (s_req) chk("imem_addr", s_addr, exp_addr);
    if (s_ready) begin
      if (exp_q.size() == 0) fail_now("head_without_fetch");
      else begin
        chk("o_pc", s_pc, exp_q[0].pc);
        chk("o_instr", instr, exp_q[0].instr);
      end
    end
    if (en_v && s_ready && !br_v) begin
      if (exp_q.size() > 0) exp_q.delete(0);
      n_pops++;
    end
    if (s_grant) begin
      mq.push_back('{addr: s_addr, due: cyc + lat_v});
      exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    if (br_v) begin
      exp_q.delete();
      exp_addr = {tgt_v[31:2], 2'b00};
    end
    prev_br = br_v;
    cyc++;
  endtask

  initial begin
    bit got_a0, got_a1, got_pc;
    int unsigned n;

    n_pass = 0; n_tot = 0; cyc = 0; n_pops = 0;
    en_v = 1'b0; br_v = 1'b0; gnt_v = 1'b0; tgt_v = '0; lat_v = 1;
    exp_addr = RESET_PC; prev_br = 1'b0;
    rst_n = 1'b0; clk_en = 1'b0; branch = 1'b0; target = '0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;

    //                 lat pre t1            target        a0            a1            pc0
    vecs[0] = '{4, 3, 32'h0,          32'h0000_1003, 32'h0000_1000, 32'h0000_1004, 32'h0000_1000};
    vecs[1] = '{1, 2, 32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[2] = '{5, 3, 32'h0000_4000,  32'h0000_5002, 32'h0000_5000, 32'h0000_5004, 32'h0000_5000};
    vecs[3] = '{2, 4, 32'h0,          32'h0000_2001, 32'h0000_2000, 32'h0000_2004, 32'h0000_2000};
    vecs[4] = '{1, 0, 32'h0,          32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0100};

    // Reset values
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch from RESET_PC
    en_v = 1'b1; gnt_v = 1'b1; lat_v = 1;
    repeat (30) do_cycle();
    chk("stream_progress", 32'(n_pops >= 12), 32'd1);

    // Decode stall: FIFO fills to depth, req drops, head held
    en_v = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_cycle();
      if (k >= 4) begin
        chk("stall_ready", 32'(s_ready), 32'd1);
        chk("stall_req", 32'(s_req), 32'd0);
      end
    end
    en_v = 1'b1;
    do_cycle();
    chk("drain_first_ready", 32'(s_ready), 32'd1);
    do_cycle();
    chk("drain_second_ready", 32'(s_ready), 32'd1);

    // Grant withheld: req and addr held, decode starves
    gnt_v = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_cycle();
      if (k >= 3) begin
        chk("nognt_req", 32'(s_req), 32'd1);
        chk("nognt_ready", 32'(s_ready), 32'd0);
      end
    end
    gnt_v = 1'b1;
    repeat (10) do_cycle();

    // Redirect vectors
    foreach (vecs[i]) begin
      lat_v = vecs[i].lat; en_v = 1'b1; gnt_v = 1'b1; br_v = 1'b0;
      repeat (vecs[i].pre) do_cycle();
      if (vecs[i].t1 != 32'h0) begin
        br_v = 1'b1; tgt_v = vecs[i].t1;
        do_cycle();
      end
      br_v = 1'b1; tgt_v = vecs[i].target;
      do_cycle();
      br_v = 1'b0;
      got_a0 = 1'b0; got_a1 = 1'b0; got_pc = 1'b0; n = 0;
      while (!(got_a0 && got_a1 && got_pc) && n < 60) begin
        do_cycle();
        n++;
        if (s_grant) begin
          if (!got_a0) begin chk("vec_addr0", s_addr, vecs[i].a0); got_a0 = 1'b1; end
          else if (!got_a1) begin chk("vec_addr1", s_addr, vecs[i].a1); got_a1 = 1'b1; end
        end
        if (s_ready && !got_pc) begin
          chk("vec_first_pc", s_pc, vecs[i].pc0);
          got_pc = 1'b1;
        end
      end
      if (!(got_a0 && got_a1 && got_pc)) fail_now("vec_timeout");
    end

    // Reset with requests in flight and buffered words
    en_v = 1'b0; lat_v = 3; gnt_v = 1'b1; br_v = 1'b0;
    repeat (3) do_cycle();
    @(negedge clk);
    rst_n = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.gnt = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    mq.delete(); exp_q.delete(); exp_addr = RESET_PC; prev_br = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en_v = 1'b1; lat_v = 1;
    got_a0 = 1'b0; got_pc = 1'b0; n = 0;
    while (!(got_a0 && got_pc) && n < 20) begin
      do_cycle();
      n++;
      if (s_grant && !got_a0) begin chk("refetch_addr", s_addr, RESET_PC); got_a0 = 1'b1; end
      if (s_ready && !got_pc) begin chk("refetch_pc", s_pc, RESET_PC); got_pc = 1'b1; end
    end
    if (!(got_a0 && got_pc)) fail_now("refetch_timeout");

    // Random traffic: stalls, grant gaps, varying latency, occasional redirects
    for (int k = 0; k < 400; k++) begin
      en_v  = ($urandom_range(0, 3) != 0);
      gnt_v = ($urandom_range(0, 9) < 7);
      lat_v = $urandom_range(1, 3);
      br_v  = ($urandom_range(0, 24) == 0);
      tgt_v = $urandom;
      do_cycle();
    end

    // Final drain
    en_v = 1'b1; gnt_v = 1'b1; br_v = 1'b0; lat_v = 1;
    repeat (20) do_cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
